// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction fetch stage with a credit-checked prefetch FIFO.
// Drives the PC and issues reads to synchronous program memory (1-cycle latency).
// Fetched words are buffered in a QUEUE_DEPTH-entry FIFO that ID drains via valid/ready.
// A branch redirect flushes the FIFO and drops the in-flight read.
// Optional feature macro: IF_FETCH_STATS_EN (flush / bubble statistics counters).
// Ports:
//   i_clock, i_reset          clock, async active-high reset
//   i_enable                  fetch enable (debug run/step)
//   i_redirect, i_redirect_addr  taken branch/jump and its target
//   o_imem_en, o_imem_addr    memory read request / address (= PC)
//   i_imem_data               read data, valid the cycle after o_imem_en
//   o_valid, i_ready          FIFO head handshake with ID
//   o_instruction             head word, NOP_INSTR when empty
//   o_pc_plus1                head address + 1, 0 when empty
//   o_pc                      current fetch PC
//   o_flush_count             redirects seen (stats build, else 0)
//   o_bubble_count            starved cycles (stats build, else 0)
module if_fetch_queue #(
  parameter int ADDR_WIDTH = 11,
  parameter int INSTR_WIDTH = 32,
  parameter int QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h00210824
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic                   i_redirect,
  input  logic [ADDR_WIDTH-1:0]  i_redirect_addr,
  output logic                   o_imem_en,
  output logic [ADDR_WIDTH-1:0]  o_imem_addr,
  input  logic [INSTR_WIDTH-1:0] i_imem_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [INSTR_WIDTH-1:0] o_instruction,
  output logic [ADDR_WIDTH-1:0]  o_pc_plus1,
  output logic [ADDR_WIDTH-1:0]  o_pc,
  output logic [15:0]            o_flush_count,
  output logic [15:0]            o_bubble_count
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam logic [PTR_W+1:0] DEPTH_V =
    (PTR_W+2)'(QUEUE_DEPTH);

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] tag;
  logic                  inflight;

  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  logic [PTR_W:0] count;
  logic [PTR_W+1:0] credit;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] rd_idx;

  logic [INSTR_WIDTH-1:0] q_instr [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0]  q_pc1   [QUEUE_DEPTH];

  logic empty;
  logic full;
  logic issue;
  logic push;
  logic pop;

  assign wr_idx = wr_ptr[PTR_W-1:0];
  assign rd_idx = rd_ptr[PTR_W-1:0];
  assign count  = wr_ptr - rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_idx == rd_idx);

  // Credits count the in-flight read as occupied and
  // ignore a same-cycle pop, so a response always fits.
  assign credit = {1'b0, count} +
                  (PTR_W+2)'(inflight);

  assign issue = ~i_reset & i_enable & ~i_redirect &
                 (credit < DEPTH_V);
  assign push  = inflight & ~i_redirect & ~full;
  assign pop   = ~empty & i_ready & ~i_redirect;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      pc       <= RESET_PC;
      tag      <= RESET_PC;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (i_redirect) begin
      pc       <= i_redirect_addr;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc  <= pc + ADDR_WIDTH'(1);
        tag <= pc;
      end
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  // Storage needs no reset: it is only read when the
  // pointers say the slot holds a pushed word.
  always_ff @(posedge i_clock) begin
    if (push) begin
      q_instr[wr_idx] <= i_imem_data;
      q_pc1[wr_idx]   <= tag + ADDR_WIDTH'(1);
    end
  end

  assign o_imem_en     = issue;
  assign o_imem_addr   = pc;
  assign o_pc          = pc;
  assign o_valid       = ~empty;
  assign o_instruction = empty ? NOP_INSTR
                               : q_instr[rd_idx];
  assign o_pc_plus1    = empty ? '0 : q_pc1[rd_idx];

`ifdef IF_FETCH_STATS_EN
  logic [15:0] flush_q;
  logic [15:0] bubble_q;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      flush_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (i_redirect && flush_q != 16'hFFFF)
        flush_q <= flush_q + 16'd1;
      if (i_ready && empty && bubble_q != 16'hFFFF)
        bubble_q <= bubble_q + 16'd1;
    end
  end

  assign o_flush_count  = flush_q;
  assign o_bubble_count = bubble_q;
`else
  assign o_flush_count  = 16'h0000;
  assign o_bubble_count = 16'h0000;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: directed bench for if_fetch_queue.
// Program memory model returns mem[k] = k with one cycle of latency.
module tb_if_fetch_queue;

  localparam logic [31:0] NOP = 32'h00210824;

  logic        clk;
  logic        rst;
  logic        en;
  logic        redir;
  logic [10:0] raddr;
  logic        imem_en;
  logic [10:0] imem_addr;
  logic [31:0] imem_data;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [10:0] pc_plus1;
  logic [10:0] pc;
  logic [15:0] flush_count;
  logic [15:0] bubble_count;

  int n_cmp;
  int n_err;
  int n_iss;
  logic [10:0] iss_addr [4];

  if_fetch_queue dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_enable        (en),
    .i_redirect      (redir),
    .i_redirect_addr (raddr),
    .o_imem_en       (imem_en),
    .o_imem_addr     (imem_addr),
    .i_imem_data     (imem_data),
    .o_valid         (valid),
    .i_ready         (ready),
    .o_instruction   (instr),
    .o_pc_plus1      (pc_plus1),
    .o_pc            (pc),
    .o_flush_count   (flush_count),
    .o_bubble_count  (bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_en) imem_data <= {21'h0, imem_addr};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    en = 1'b0;
    redir = 1'b0;
    raddr = '0;
    ready = 1'b0;
    imem_data = '0;
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", 32'(valid), 0);
    chk("rst_en", 32'(imem_en), 0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc1", 32'(pc_plus1), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    chk("rst_flush", 32'(flush_count), 0);
    chk("rst_bubble", 32'(bubble_count), 0);
    tick();
    tick();

    // 1: streaming at one instruction per cycle
    rst = 1'b0;
    en = 1'b1;
    ready = 1'b1;
    #1;
    chk("t1_en0", 32'(imem_en), 1);
    chk("t1_addr0", 32'(imem_addr), 0);
    chk("t1_v0", 32'(valid), 0);
    tick();
    chk("t1_addr1", 32'(imem_addr), 1);
    chk("t1_v1", 32'(valid), 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("t1_valid", 32'(valid), 1);
      chk("t1_instr", instr, 32'(k));
      chk("t1_pc1", 32'(pc_plus1), 32'(k + 1));
      tick();
    end

    // 2: back-pressure fills the FIFO, then drains in order
    do_reset();
    rst = 1'b0;
    en = 1'b1;
    ready = 1'b0;
    n_iss = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (imem_en) begin
        if (n_iss < 4) iss_addr[n_iss] = imem_addr;
        n_iss++;
      end
      tick();
    end
    chk("t2_issues", 32'(n_iss), 4);
    for (int k = 0; k < 4; k++)
      chk("t2_iss_addr", 32'(iss_addr[k]), 32'(k));
    chk("t2_en_off", 32'(imem_en), 0);
    chk("t2_full_v", 32'(valid), 1);
    ready = 1'b1;
    #1;
    chk("t2_d0", instr, 0);
    chk("t2_en_a", 32'(imem_en), 0);
    tick();
    chk("t2_d1", instr, 1);
    chk("t2_resume_en", 32'(imem_en), 1);
    chk("t2_resume_addr", 32'(imem_addr), 4);
    tick();
    chk("t2_d2", instr, 2);
    tick();
    chk("t2_d3", instr, 3);
    tick();
    chk("t2_d4", instr, 4);
    chk("t2_d4_pc1", 32'(pc_plus1), 5);

    // 3: redirect with 3 queued words and a read in flight
    do_reset();
    rst = 1'b0;
    en = 1'b1;
    ready = 1'b0;
    repeat (4) tick();
    chk("t3_pre_v", 32'(valid), 1);
    redir = 1'b1;
    raddr = 11'h100;
    ready = 1'b1;
    #1;
    chk("t3_r_en", 32'(imem_en), 0);
    tick();
    redir = 1'b0;
    #1;
    chk("t3_r1_v", 32'(valid), 0);
    chk("t3_r1_nop", instr, NOP);
    chk("t3_r1_pc1", 32'(pc_plus1), 0);
    chk("t3_r1_pc", 32'(pc), 32'h100);
    chk("t3_r1_addr", 32'(imem_addr), 32'h100);
    chk("t3_r1_en", 32'(imem_en), 1);
    tick();
    chk("t3_r2_v", 32'(valid), 0);
    chk("t3_r2_addr", 32'(imem_addr), 32'h101);
    tick();
    chk("t3_r3_v", 32'(valid), 1);
    chk("t3_r3_instr", instr, 32'h100);
    chk("t3_r3_pc1", 32'(pc_plus1), 32'h101);
    tick();
    chk("t3_r4_instr", instr, 32'h101);
    chk("t3_r4_pc1", 32'(pc_plus1), 32'h102);

    // 4: redirect to the top of the address space wraps
    redir = 1'b1;
    raddr = 11'h7FF;
    tick();
    redir = 1'b0;
    #1;
    chk("t4_addr_top", 32'(imem_addr), 32'h7FF);
    chk("t4_flushed", 32'(valid), 0);
    tick();
    chk("t4_addr_wrap", 32'(imem_addr), 0);
    tick();
    chk("t4_instr_top", instr, 32'h7FF);
    chk("t4_pc1_wrap", 32'(pc_plus1), 0);
    tick();
    chk("t4_instr_0", instr, 0);
    chk("t4_pc1_1", 32'(pc_plus1), 1);

    // 5: asynchronous reset mid-stream
    ready = 1'b0;
    tick();
    chk("t5_pre_v", 32'(valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_v", 32'(valid), 0);
    chk("t5_instr", instr, NOP);
    chk("t5_pc1", 32'(pc_plus1), 0);
    chk("t5_pc", 32'(pc), 0);
    chk("t5_en", 32'(imem_en), 0);
    tick();
    tick();
    rst = 1'b0;
    ready = 1'b1;
    #1;
    chk("t5_restart_addr", 32'(imem_addr), 0);
    chk("t5_restart_en", 32'(imem_en), 1);
    tick();
    tick();
    chk("t5_restart_instr", instr, 0);
    chk("t5_restart_pc1", 32'(pc_plus1), 1);

    // 6: statistics, 3 redirects then 5 starved cycles
    do_reset();
    rst = 1'b0;
    en = 1'b0;
    ready = 1'b0;
    tick();
    redir = 1'b1;
    raddr = 11'h020;
    tick();
    tick();
    tick();
    redir = 1'b0;
    ready = 1'b1;
    repeat (5) tick();
    ready = 1'b0;
    tick();
`ifdef IF_FETCH_STATS_EN
    chk("t6_flush", 32'(flush_count), 3);
    chk("t6_bubble", 32'(bubble_count), 5);
`else
    chk("t6_flush", 32'(flush_count), 0);
    chk("t6_bubble", 32'(bubble_count), 0);
`endif
    chk("t6_pc", 32'(pc), 32'h020);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
